shift_issue: RTL and testbench
==============================

SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  command offered.
REQ-005 SHALL have port in_ready  output  1  command accepted this cycle when in_valid=1.
REQ-006 SHALL have port in_data  input  8  operand.
REQ-007 SHALL have port in_n  input  4  shift amount.
REQ-008 SHALL have ports in_ar, in_lr, in_rot  input  1 each  arithmetic, left (1) / right (0), rotate.
REQ-009 SHALL have ports sh_i (8), sh_n (4), sh_ar, sh_lr, sh_rot (1 each)  output  operands driven to the combinational 8-bit shifter.
REQ-010 SHALL have port sh_o  input  8  shifter result, combinational from sh_*.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port out_data  output  8  result.
REQ-014 SHALL have port out_err  output  1  result belongs to an illegal command (in_n > 8).
REQ-015 SHALL have port count  output  5  current FIFO occupancy, 0..DEPTH.

Function
REQ-016 SHALL accept a command (push) when in_valid & in_ready; in_ready = (count < DEPTH), no combinational path from out_ready.
REQ-017 SHALL store per entry: data, n, ar, lr, rot, err, where err = (in_n > 8).
REQ-018 SHALL drive sh_* from the FIFO head entry registers only, with sh_n = n if err=0, else 0; all sh_* = 0 when count = 0.
REQ-019 SHALL hold a one-entry result register (out_data, out_err, out_valid).
REQ-020 SHALL pop the head and load the result register when count > 0 and (out_valid = 0 or out_ready = 1).
REQ-021 SHALL load out_data = sh_o, out_err = 0 for err=0 heads; out_data = 8'h00, out_err = 1 for err=1 heads.
REQ-022 SHALL clear out_valid on out_ready & out_valid when no pop occurs in the same cycle.
REQ-023 SHALL give latency: command pushed at edge k into an empty FIFO with empty result slot -> out_valid = 1 after edge k+1.
REQ-024 SHALL handle simultaneous push and pop: count unchanged; push while full is impossible (in_ready = 0), even if a pop occurs that cycle.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; count tracks occupancy exactly.
REQ-026 SHALL preserve command order; results emerge in acceptance order, no drops, no duplicates.
REQ-027 SHALL hold out_data / out_err stable while out_valid = 1 and out_ready = 0.
REQ-028 SHALL sustain throughput of one command per cycle when out_ready is held at 1.

Reset
REQ-029 SHALL, on rst = 1 (asynchronous), immediately set count = 0, pointers = 0, out_valid = 0, out_data = 8'h00, out_err = 0, sh_* = 0, and in_ready = 1 after release.
REQ-030 SHALL discard all queued commands and any pending result on reset mid-operation; no output after release until new commands arrive.

Verification (bench connects the team's 8-bit shifter on sh_*)
REQ-031 SHALL check single command: data 0x96, n=3, lr=1, ar=0, rot=0 -> out_valid after 2nd edge, out_data 0xB0, out_err 0.
REQ-032 SHALL check back-to-back, out_ready=1: (0x96, n=2, ar=1, lr=0) then (0x96, n=4, rot=1, lr=0) -> 0xE5 then 0x69 on consecutive cycles.
REQ-033 SHALL check backpressure: out_ready=0, push DEPTH+1 commands -> in_ready drops after result slot plus DEPTH accepted (count=4); out_data held; release drains in order.
REQ-034 SHALL check illegal amount: n=9 -> sh_n=0 while at head, out_data 0x00, out_err 1; next legal command gives out_err 0.
REQ-035 SHALL check full FIFO with simultaneous out_ready=1 and in_valid=1 -> no push that cycle, count decrements by 1.
REQ-036 SHALL check rst pulse asserted mid-stream with 3 queued commands -> out_valid=0 and count=0 immediately, no stale result after release.

Source files
------------

// File: rtl/shift_issue_if.sv
// Command/result handshake and shifter operand bus for shift_issue.
interface shift_issue_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [3:0] in_n;
   logic       in_ar;
   logic       in_lr;
   logic       in_rot;
   logic [7:0] sh_i;
   logic [3:0] sh_n;
   logic       sh_ar;
   logic       sh_lr;
   logic       sh_rot;
   logic [7:0] sh_o;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_err;

   modport slave (
      input  in_valid, in_data, in_n, in_ar, in_lr, in_rot, sh_o, out_ready,
      output in_ready, sh_i, sh_n, sh_ar, sh_lr, sh_rot, out_valid, out_data, out_err
   );

   modport master (
      output in_valid, in_data, in_n, in_ar, in_lr, in_rot, sh_o, out_ready,
      input  in_ready, sh_i, sh_n, sh_ar, sh_lr, sh_rot, out_valid, out_data, out_err
   );
endinterface

// File: rtl/shift_issue.sv
// Shift command FIFO feeding an external combinational shifter, with a
// one-entry result register on the output handshake.
module shift_issue #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   shift_issue_if.slave bus,
   output logic [4:0]   count
);
   localparam int         PW      = $clog2(DEPTH);
   localparam logic [4:0] DEPTH_C = 5'(DEPTH);

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] n;
      logic       ar;
      logic       lr;
      logic       rot;
      logic       err;
   } cmd_t;

   cmd_t          mem_q [DEPTH];
   cmd_t          head;
   cmd_t          wr_cmd;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [4:0]    count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic [7:0]    out_data_q, out_data_d;
   logic          out_err_q, out_err_d;
   logic          push;
   logic          pop;

   assign push = bus.in_valid && (count_q < DEPTH_C);
   assign pop  = (count_q != 5'd0) && (!out_valid_q || bus.out_ready);

   assign wr_cmd = '{data: bus.in_data, n: bus.in_n, ar: bus.in_ar, lr: bus.in_lr,
                     rot: bus.in_rot, err: (bus.in_n > 4'd8)};

   // Empty FIFO presents an all-zero head so the shifter sees quiet operands.
   always_comb begin
      head = '0;
      if (count_q != 5'd0) head = mem_q[rptr_q];
   end

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop) begin
         rptr_d      = rptr_q + PW'(1);
         out_valid_d = 1'b1;
         out_data_d  = head.err ? 8'h00 : bus.sh_o;
         out_err_d   = head.err;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      count_d = count_q + {4'd0, push} - {4'd0, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= 5'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_err_q   <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wr_cmd;
   end

   // Illegal amounts reach the shifter as a zero shift.
   assign bus.sh_i      = head.data;
   assign bus.sh_n      = head.err ? 4'd0 : head.n;
   assign bus.sh_ar     = head.ar;
   assign bus.sh_lr     = head.lr;
   assign bus.sh_rot    = head.rot;
   assign bus.in_ready  = (count_q < DEPTH_C);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_err   = out_err_q;
   assign count         = count_q;
endmodule

// File: tb/tb_shift_issue.sv
// Bench for shift_issue: directed scenarios plus a queue-based reference model
// that predicts occupancy, head operands and results every cycle.
module tb_shift_issue;
   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0] d;
      logic [3:0] n;
      logic       ar;
      logic       lr;
      logic       rot;
   } tcmd_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] count;
   int         vectors = 0;
   int         miscompares = 0;
   tcmd_t      fifo_m[$];
   logic [8:0] slot_m[$];

   shift_issue_if bus();

   shift_issue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   // Team shifter: one bit position per step.
   function automatic logic [7:0] team_shift(input logic [7:0] d, input logic [3:0] n,
                                             input logic ar, input logic lr, input logic rot);
      logic [7:0] r;
      r = d;
      for (int k = 0; k < int'(n); k++) begin
         if (rot)     r = lr ? {r[6:0], r[7]} : {r[0], r[7:1]};
         else if (lr) r = {r[6:0], 1'b0};
         else         r = {ar & r[7], r[7:1]};
      end
      return r;
   endfunction

   always_comb bus.sh_o = team_shift(bus.sh_i, bus.sh_n, bus.sh_ar, bus.sh_lr, bus.sh_rot);

   // Expected {err, data} for a command, from plain shift arithmetic.
   function automatic logic [8:0] ref_result(input tcmd_t c);
      logic [15:0]       w;
      logic signed [7:0] sd;
      logic [7:0]        r;
      int                s;
      if (c.n > 4'd8) return {1'b1, 8'h00};
      s = int'(c.n);
      if (c.rot) begin
         w = {c.d, c.d};
         if (c.lr) begin w = w << s; r = w[15:8]; end
         else      begin w = w >> s; r = w[7:0];  end
      end else if (c.lr) begin
         w = {8'h00, c.d} << s;
         r = w[7:0];
      end else if (c.ar) begin
         sd = c.d;
         r  = sd >>> s;
      end else begin
         r = c.d >> s;
      end
      return {1'b0, r};
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         logic  do_push, do_pop;
         tcmd_t c;
         vectors++;
         if (count !== 5'(fifo_m.size())) begin
            miscompares++;
            $display("FAIL mon_count got %0d expected %0d", count, fifo_m.size());
         end
         vectors++;
         if (bus.in_ready !== (fifo_m.size() < DEPTH)) begin
            miscompares++;
            $display("FAIL mon_in_ready got %b expected %b", bus.in_ready, fifo_m.size() < DEPTH);
         end
         vectors++;
         if (bus.out_valid !== (slot_m.size() != 0)) begin
            miscompares++;
            $display("FAIL mon_out_valid got %b expected %b", bus.out_valid, slot_m.size() != 0);
         end
         if (slot_m.size() != 0) begin
            vectors++;
            if ({bus.out_err, bus.out_data} !== slot_m[0]) begin
               miscompares++;
               $display("FAIL mon_result got err=%b data=%h expected err=%b data=%h",
                        bus.out_err, bus.out_data, slot_m[0][8], slot_m[0][7:0]);
            end
         end
         vectors++;
         if (fifo_m.size() != 0) begin
            c = fifo_m[0];
            if ({bus.sh_i, bus.sh_n, bus.sh_ar, bus.sh_lr, bus.sh_rot} !==
                {c.d, (c.n > 4'd8) ? 4'd0 : c.n, c.ar, c.lr, c.rot}) begin
               miscompares++;
               $display("FAIL mon_sh got i=%h n=%0d expected i=%h n=%0d", bus.sh_i, bus.sh_n,
                        c.d, (c.n > 4'd8) ? 4'd0 : c.n);
            end
         end else if ({bus.sh_i, bus.sh_n, bus.sh_ar, bus.sh_lr, bus.sh_rot} !== 15'd0) begin
            miscompares++;
            $display("FAIL mon_sh_idle got i=%h n=%0d expected 0", bus.sh_i, bus.sh_n);
         end
         do_push = bus.in_valid && (fifo_m.size() < DEPTH);
         do_pop  = (fifo_m.size() != 0) && ((slot_m.size() == 0) || bus.out_ready);
         if (bus.out_ready && slot_m.size() != 0) void'(slot_m.pop_front());
         if (do_pop) slot_m.push_back(ref_result(fifo_m.pop_front()));
         if (do_push) begin
            c = '{d: bus.in_data, n: bus.in_n, ar: bus.in_ar, lr: bus.in_lr, rot: bus.in_rot};
            fifo_m.push_back(c);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] n,
                        input logic ar, input logic lr, input logic rot);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_n     = n;
      bus.in_ar    = ar;
      bus.in_lr    = lr;
      bus.in_rot   = rot;
   endtask

   task automatic push_cmd(input logic [7:0] d, input logic [3:0] n,
                           input logic ar, input logic lr, input logic rot);
      logic rdy, acc;
      acc = 1'b0;
      drive(1'b1, d, n, ar, lr, rot);
      for (int i = 0; i < 64; i++) begin
         rdy = bus.in_ready;
         tick();
         if (rdy) begin acc = 1'b1; break; end
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (!acc) begin
         miscompares++;
         $display("FAIL push_timeout got no accept expected accept");
      end
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (count == 5'd0 && !bus.out_valid) begin done = 1'b1; break; end
         tick();
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL drain_timeout got count=%0d valid=%b expected empty", count, bus.out_valid);
      end
   endtask

   task automatic test_reset();
      drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      #1 rst = 1'b1;
      #2;
      vectors++;
      if ({count, bus.out_valid, bus.out_data, bus.out_err} !== 15'd0) begin
         miscompares++;
         $display("FAIL reset_state got count=%0d valid=%b data=%h err=%b expected 0",
                  count, bus.out_valid, bus.out_data, bus.out_err);
      end
      vectors++;
      if ({bus.sh_i, bus.sh_n, bus.sh_ar, bus.sh_lr, bus.sh_rot} !== 15'd0) begin
         miscompares++;
         $display("FAIL reset_sh got i=%h n=%0d expected 0", bus.sh_i, bus.sh_n);
      end
      tick();
      rst = 1'b0;
      tick();
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready got %b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_single();
      bus.out_ready = 1'b0;
      drive(1'b1, 8'h96, 4'd3, 1'b0, 1'b1, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      vectors++;
      if (count !== 5'd1 || bus.out_valid !== 1'b0 || bus.sh_i !== 8'h96 || bus.sh_n !== 4'd3) begin
         miscompares++;
         $display("FAIL single_first_edge got count=%0d valid=%b sh_i=%h sh_n=%0d expected 1 0 96 3",
                  count, bus.out_valid, bus.sh_i, bus.sh_n);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hB0 || bus.out_err !== 1'b0) begin
         miscompares++;
         $display("FAIL single_result got valid=%b data=%h err=%b expected 1 b0 0",
                  bus.out_valid, bus.out_data, bus.out_err);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      drive(1'b1, 8'h96, 4'd2, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 8'h96, 4'd4, 1'b0, 1'b0, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE5) begin
         miscompares++;
         $display("FAIL b2b_first got valid=%b data=%h expected 1 e5", bus.out_valid, bus.out_data);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h69) begin
         miscompares++;
         $display("FAIL b2b_second got valid=%b data=%h expected 1 69", bus.out_valid, bus.out_data);
      end
      drain();
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      push_cmd(8'h96, 4'd3, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         push_cmd(8'($urandom), 4'($urandom_range(0, 8)), 1'($urandom), 1'($urandom), 1'($urandom));
      drive(1'b1, 8'h3C, 4'd1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (count !== 5'(DEPTH) || bus.in_ready !== 1'b0 || bus.out_data !== 8'hB0
             || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_hold got count=%0d rdy=%b valid=%b data=%h expected 4 0 1 b0",
                     count, bus.in_ready, bus.out_valid, bus.out_data);
         end
         tick();
      end
      drain();
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b0;
      drive(1'b1, 8'h5A, 4'd9, 1'b0, 1'b1, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.sh_n !== 4'd0 || bus.sh_i !== 8'h5A) begin
         miscompares++;
         $display("FAIL illegal_sh got sh_n=%0d sh_i=%h expected 0 5a", bus.sh_n, bus.sh_i);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00 || bus.out_err !== 1'b1) begin
         miscompares++;
         $display("FAIL illegal_result got valid=%b data=%h err=%b expected 1 00 1",
                  bus.out_valid, bus.out_data, bus.out_err);
      end
      bus.out_ready = 1'b1;
      drive(1'b1, 8'h81, 4'd1, 1'b1, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC0 || bus.out_err !== 1'b0) begin
         miscompares++;
         $display("FAIL legal_after_illegal got valid=%b data=%h err=%b expected 1 c0 0",
                  bus.out_valid, bus.out_data, bus.out_err);
      end
      drain();
   endtask

   task automatic test_full_pop();
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++)
         push_cmd(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      bus.out_ready = 1'b1;
      drive(1'b1, 8'hA5, 4'd2, 1'b0, 1'b1, 1'b1);
      tick();
      vectors++;
      if (count !== 5'(DEPTH - 1)) begin
         miscompares++;
         $display("FAIL full_pop_count got %0d expected %0d", count, DEPTH - 1);
      end
      tick();
      bus.in_valid = 1'b0;
      vectors++;
      if (count !== 5'(DEPTH - 1)) begin
         miscompares++;
         $display("FAIL push_pop_count got %0d expected %0d", count, DEPTH - 1);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         push_cmd(8'($urandom), 4'($urandom_range(0, 8)), 1'($urandom), 1'($urandom), 1'($urandom));
      #1 rst = 1'b1;
      #1;
      fifo_m.delete();
      slot_m.delete();
      vectors++;
      if (count !== 5'd0 || bus.out_valid !== 1'b0 || bus.sh_i !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_mid got count=%0d valid=%b sh_i=%h expected 0 0 00",
                  count, bus.out_valid, bus.sh_i);
      end
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (bus.out_valid !== 1'b0 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_stale got valid=%b count=%0d expected 0 0", bus.out_valid, count);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
         bus.out_ready = (i % 100 < 50) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0);
         tick();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
